// File: rtl/ex_alu_control.sv
// ex_alu_control
//   EX-stage ALU control decoder for the MIPS pipeline. Turns the 2-bit ALU-op
//   class from the ID/EX register, plus the R-type funct field, into the 3-bit
//   operation select driven into the EX-stage ALU. Both outputs are registered,
//   so the result appears one clock after the inputs are sampled.
//
//   Ports
//     clk               in   1  clock, all state updates on the rising edge
//     rst               in   1  synchronous reset, active-high
//     EX_alu_op         in   2  class: 00 add, 01 sub, 10 R-type, 11 or
//     EX_funct          in   6  instruction bits [5:0], decoded only for class 10
//     EX_alu_select     out  3  ALU select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//     EX_funct_invalid  out  1  R-type funct that has no ALU mapping
module ex_alu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] EX_alu_op,
  input  logic [5:0] EX_funct,
  output logic [2:0] EX_alu_select,
  output logic       EX_funct_invalid
);

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  logic [2:0] alu_select_d, alu_select_q;
  logic       funct_invalid_d, funct_invalid_q;

  always_comb begin
    alu_select_d    = SEL_ADD;
    funct_invalid_d = 1'b0;
    unique case (EX_alu_op)
      2'b00: alu_select_d = SEL_ADD;
      2'b01: alu_select_d = SEL_SUB;
      2'b11: alu_select_d = SEL_OR;
      2'b10: begin
        // Signed/unsigned variants share an ALU operation; the overflow
        // distinction is handled outside this decoder.
        case (EX_funct)
          6'b100000, 6'b100001: alu_select_d = SEL_ADD;
          6'b100010, 6'b100011: alu_select_d = SEL_SUB;
          6'b100100:            alu_select_d = SEL_AND;
          6'b100101:            alu_select_d = SEL_OR;
          6'b101010, 6'b101011: alu_select_d = SEL_SLT;
          default: begin
            // Unmapped funct falls back to ADD so the ALU still produces a
            // defined value; the flag lets the core raise the exception.
            alu_select_d    = SEL_ADD;
            funct_invalid_d = 1'b1;
          end
        endcase
      end
      default: begin
        alu_select_d    = SEL_ADD;
        funct_invalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_select_q    <= SEL_ADD;
      funct_invalid_q <= 1'b0;
    end else begin
      alu_select_q    <= alu_select_d;
      funct_invalid_q <= funct_invalid_d;
    end
  end

  assign EX_alu_select    = alu_select_q;
  assign EX_funct_invalid = funct_invalid_q;

endmodule

// File: tb/tb_ex_alu_control.sv
// Directed bench for ex_alu_control. Each step drives inputs on the falling
// edge, queues the expected registered result, confirms the outputs did not
// move with the new inputs, then pops and compares just after the rising edge.
module tb_ex_alu_control;

  logic       clk;
  logic       rst;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [2:0] alu_select;
  logic       funct_invalid;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];       // {select, invalid} in issue order
  logic [3:0] last_exp;
  logic       last_valid = 1'b0;

  ex_alu_control dut (
    .clk              (clk),
    .rst              (rst),
    .EX_alu_op        (alu_op),
    .EX_funct         (funct),
    .EX_alu_select    (alu_select),
    .EX_funct_invalid (funct_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written straight from the opcode/funct table.
  function automatic logic [3:0] model(input logic r, input logic [1:0] op, input logic [5:0] f);
    if (r) return {3'b010, 1'b0};
    case (op)
      2'b00: return {3'b010, 1'b0};
      2'b01: return {3'b110, 1'b0};
      2'b11: return {3'b001, 1'b0};
      default: begin
        case (f)
          6'd32, 6'd33: return {3'b010, 1'b0};
          6'd34, 6'd35: return {3'b110, 1'b0};
          6'd36:        return {3'b000, 1'b0};
          6'd37:        return {3'b001, 1'b0};
          6'd42, 6'd43: return {3'b111, 1'b0};
          default:      return {3'b010, 1'b1};
        endcase
      end
    endcase
  endfunction

  task automatic step(input logic r, input logic [1:0] op, input logic [5:0] f, input string tag);
    logic [3:0] e;
    @(negedge clk);
    rst    = r;
    alu_op = op;
    funct  = f;
    exp_q.push_back(model(r, op, f));
    #1;
    // Registered outputs must still show the previous result.
    if (last_valid) begin
      checks++;
      assert ({alu_select, funct_invalid} === last_exp) else begin
        failures++;
        $error("FAIL %s_hold observed=%b expected=%b", tag, {alu_select, funct_invalid}, last_exp);
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (alu_select === e[3:1]) else begin
        failures++;
        $error("FAIL %s_sel observed=%b expected=%b", tag, alu_select, e[3:1]);
      end
      checks++;
      assert (funct_invalid === e[0]) else begin
        failures++;
        $error("FAIL %s_inv observed=%b expected=%b", tag, funct_invalid, e[0]);
      end
      last_exp   = e;
      last_valid = 1'b1;
    end
    $display("step %-10s rst=%b op=%b funct=%b -> sel=%b inv=%b", tag, r, op, f, alu_select, funct_invalid);
  endtask

  initial begin
    rst    = 1'b1;
    alu_op = 2'b10;
    funct  = 6'b100010;

    // Reset wins over an R-type sub.
    step(1'b1, 2'b10, 6'b100010, "reset");

    // Class decode, funct ignored.
    step(1'b0, 2'b00, 6'b100000, "cls_add");
    step(1'b0, 2'b01, 6'b111111, "cls_sub");
    step(1'b0, 2'b11, 6'b101010, "cls_or");

    // R-type sweep, back-to-back.
    step(1'b0, 2'b10, 6'b100000, "r_add");
    step(1'b0, 2'b10, 6'b100010, "r_sub");
    step(1'b0, 2'b10, 6'b100100, "r_and");
    step(1'b0, 2'b10, 6'b100101, "r_or");
    step(1'b0, 2'b10, 6'b101010, "r_slt");
    step(1'b0, 2'b10, 6'b100001, "r_addu");
    step(1'b0, 2'b10, 6'b100011, "r_subu");
    step(1'b0, 2'b10, 6'b101011, "r_sltu");

    // Illegal funct codes, then recovery.
    step(1'b0, 2'b10, 6'b000000, "ill_00");
    step(1'b0, 2'b10, 6'b111111, "ill_3f");
    step(1'b0, 2'b00, 6'b111111, "ill_clr");
    step(1'b0, 2'b10, 6'b101100, "ill_2c");

    // Reset pulse in the middle of a sweep.
    step(1'b0, 2'b10, 6'b100100, "mid_pre");
    step(1'b1, 2'b10, 6'b101010, "mid_rst");
    step(1'b0, 2'b10, 6'b101010, "mid_post");
    step(1'b0, 2'b10, 6'b000111, "mid_ill");
    step(1'b0, 2'b11, 6'b000111, "mid_or");

    // Short pseudo-random run through the same model.
    for (int i = 0; i < 16; i++) begin
      step(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), "rand");
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
